// File: rtl/mem_req_sequencer_if.sv
// Purpose: request, memory-port and response signals of mem_req_sequencer.
// Latency: none, wires only.
// Backpressure: req_ready/rsp_ready handshakes carried through unchanged.
interface mem_req_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;

    // Sequencer side.
    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata, mem_rdata, rsp_ready,
        output req_ready, mem_rw, mem_addr, mem_wdata, rsp_valid, rsp_data
    );

    // Requester/memory side.
    modport master (
        output req_valid, req_rw, req_addr, req_wdata, mem_rdata, rsp_ready,
        input  req_ready, mem_rw, mem_addr, mem_wdata, rsp_valid, rsp_data
    );
endinterface

// File: rtl/mem_req_sequencer.sv
// Purpose: one memory op per accepted request; read data returned via a credit-protected response FIFO.
// Latency: memory op 1 cycle after accept, response pushed 2 cycles after accept.
// Backpressure: req_ready drops when in-flight reads plus FIFO occupancy reach DEPTH; optional
//   MEM_REQ_SEQ_WR_ACK_EN also returns a response (the written data) for every accepted write.
module mem_req_sequencer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_req_sequencer_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OUT_W = $clog2(DEPTH + 3);

    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              rd_p1_q, rd_p1_d;
    logic              rd_p2_q, rd_p2_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  fifo_count_q, fifo_count_d;
    logic [DATA_W-1:0] fifo_mem_q [DEPTH];
    logic [DATA_W-1:0] fifo_mem_d [DEPTH];
`ifdef MEM_REQ_SEQ_WR_ACK_EN
    logic              p1_wr_q, p1_wr_d;
    logic              p2_wr_q, p2_wr_d;
    logic [DATA_W-1:0] p2_dat_q, p2_dat_d;
`endif

    logic [OUT_W-1:0]  outstanding;
    logic              req_ready;
    logic              accept;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic [DATA_W-1:0] push_dat;

    // Credit decode: every response slot already promised counts, so the FIFO can never overflow.
    always_comb begin
        outstanding = OUT_W'(rd_p1_q) + OUT_W'(rd_p2_q) + OUT_W'(fifo_count_q);
        req_ready   = (outstanding < OUT_W'(DEPTH));
        accept      = bus.req_valid && req_ready;
    end

    // Issue stage: rw pulses for exactly one cycle per accepted write, address/data hold otherwise.
    always_comb begin
        mem_rw_d    = accept && bus.req_rw;
        mem_addr_d  = accept ? bus.req_addr  : mem_addr_q;
        mem_wdata_d = accept ? bus.req_wdata : mem_wdata_q;
    end

    // Response tracking pipeline aligned with the memory's registered read data.
    always_comb begin
        rd_p2_d = rd_p1_q;
`ifdef MEM_REQ_SEQ_WR_ACK_EN
        rd_p1_d  = accept;
        p1_wr_d  = accept && bus.req_rw;
        p2_wr_d  = p1_wr_q;
        p2_dat_d = p1_wr_q ? mem_wdata_q : p2_dat_q;
        push_dat = p2_wr_q ? p2_dat_q : bus.mem_rdata;
`else
        rd_p1_d  = accept && !bus.req_rw;
        push_dat = bus.mem_rdata;
`endif
    end

    // Response FIFO: circular buffer with explicit pointer wrap so DEPTH need not be a power of two.
    always_comb begin
        push         = rd_p2_q;
        pop          = bus.rsp_ready && (fifo_count_q != '0);
        fifo_full    = (fifo_count_q == CNT_W'(DEPTH));
        fifo_mem_d   = fifo_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
            2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    // State registers; reset drops in-flight reads and FIFO contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rw_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rd_p1_q      <= 1'b0;
            rd_p2_q      <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_mem_q[i] <= '0;
`ifdef MEM_REQ_SEQ_WR_ACK_EN
            p1_wr_q      <= 1'b0;
            p2_wr_q      <= 1'b0;
            p2_dat_q     <= '0;
`endif
        end else begin
            mem_rw_q     <= mem_rw_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rd_p1_q      <= rd_p1_d;
            rd_p2_q      <= rd_p2_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            fifo_mem_q   <= fifo_mem_d;
`ifdef MEM_REQ_SEQ_WR_ACK_EN
            p1_wr_q      <= p1_wr_d;
            p2_wr_q      <= p2_wr_d;
            p2_dat_q     <= p2_dat_d;
`endif
        end
    end

    // Credits guarantee a push into a full FIFO always coincides with a pop.
    assert property (@(posedge clk) disable iff (rst) !(push && !pop && fifo_full));

    assign bus.req_ready = req_ready;
    assign bus.mem_rw    = mem_rw_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_valid = (fifo_count_q != '0);
    assign bus.rsp_data  = fifo_mem_q[rd_ptr_q];
endmodule
